// File: rtl/mastermind_pkg.sv
// Shared types and defaults for the mastermind game controller and its scoring engine.
package mastermind_pkg;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_COLOR_W   = 3;
  localparam int DEF_MAX_TURNS = 10;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: taps on bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_SCORE_EXACT,
    ST_SCORE_COLOR,
    ST_REPORT,
    ST_WIN,
    ST_LOSE
  } game_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_EXACT,
    PH_COLOR
  } scorer_phase_t;

endpackage

// File: rtl/mastermind_if.sv
// Button/display bundle between the debouncers, the game controller and the LED driver.
interface mastermind_if #(
  parameter int NUM_SLOTS = mastermind_pkg::DEF_NUM_SLOTS,
  parameter int COLOR_W   = mastermind_pkg::DEF_COLOR_W
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic                         start;
  logic                         btn_left;
  logic                         btn_right;
  logic                         btn_up;
  logic                         btn_down;
  logic                         btn_submit;
  logic [NUM_SLOTS*COLOR_W-1:0] secret_in;
  logic [NUM_SLOTS*COLOR_W-1:0] guess_out;
  logic [SLOT_W-1:0]            cursor;
  logic [SLOT_W:0]              exact_cnt;
  logic [SLOT_W:0]              color_cnt;
  logic                         result_valid;
  logic [7:0]                   turn_cnt;
  logic                         busy;
  logic                         win;
  logic                         lose;

  modport master (
    output start, btn_left, btn_right, btn_up, btn_down, btn_submit, secret_in,
    input  guess_out, cursor, exact_cnt, color_cnt, result_valid, turn_cnt, busy, win, lose
  );

  modport slave (
    input  start, btn_left, btn_right, btn_up, btn_down, btn_submit, secret_in,
    output guess_out, cursor, exact_cnt, color_cnt, result_valid, turn_cnt, busy, win, lose
  );

endinterface

// File: rtl/guess_scorer.sv
// Two-pass scoring engine: one slot per cycle for exact hits, then one colour per cycle
// for total colour matches. go and done are single-cycle pulses; abort drops any pass.
module guess_scorer
  import mastermind_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int COLOR_W   = DEF_COLOR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  input  logic                         abort,
  input  logic [NUM_SLOTS*COLOR_W-1:0] guess,
  input  logic [NUM_SLOTS*COLOR_W-1:0] secret,
  output logic [$clog2(NUM_SLOTS):0]   exact,
  output logic [$clog2(NUM_SLOTS):0]   total,
  output logic                         done,
  output logic                         active,
  output logic                         color_phase
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int IDX_W  = (COLOR_W > SLOT_W) ? COLOR_W : SLOT_W;

  scorer_phase_t state, next_state;

  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   exact_acc, total_acc;
  logic [CNT_W-1:0]   g_cnt, s_cnt, min_cnt;
  logic [COLOR_W-1:0] g_slot [NUM_SLOTS];
  logic [COLOR_W-1:0] s_slot [NUM_SLOTS];
  logic               last_slot, last_color, slot_match;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      g_slot[i] = guess[i*COLOR_W +: COLOR_W];
      s_slot[i] = secret[i*COLOR_W +: COLOR_W];
    end
  end

  assign last_slot  = (idx == IDX_W'(NUM_SLOTS - 1));
  assign last_color = (idx == IDX_W'((1 << COLOR_W) - 1));
  assign slot_match = (g_slot[idx[SLOT_W-1:0]] == s_slot[idx[SLOT_W-1:0]]);

  // Occurrences of colour idx in each code; the shared part is their minimum
  always_comb begin
    g_cnt = '0;
    s_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (g_slot[i] == idx[COLOR_W-1:0]) g_cnt = g_cnt + CNT_W'(1);
      if (s_slot[i] == idx[COLOR_W-1:0]) s_cnt = s_cnt + CNT_W'(1);
    end
    min_cnt = (g_cnt < s_cnt) ? g_cnt : s_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PH_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = PH_IDLE;
    end else begin
      case (state)
        PH_IDLE:  if (go)         next_state = PH_EXACT;
        PH_EXACT: if (last_slot)  next_state = PH_COLOR;
        PH_COLOR: if (last_color) next_state = PH_IDLE;
        default:                  next_state = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      exact_acc <= '0;
      total_acc <= '0;
    end else if (abort) begin
      idx       <= '0;
      exact_acc <= '0;
      total_acc <= '0;
    end else begin
      case (state)
        PH_IDLE: begin
          if (go) begin
            idx       <= '0;
            exact_acc <= '0;
            total_acc <= '0;
          end
        end
        PH_EXACT: begin
          exact_acc <= exact_acc + CNT_W'(slot_match);
          idx       <= last_slot ? '0 : idx + IDX_W'(1);
        end
        PH_COLOR: begin
          total_acc <= total_acc + min_cnt;
          idx       <= idx + IDX_W'(1);
        end
        default: idx <= '0;
      endcase
    end
  end

  // done fires in the last colour cycle so the total includes that colour combinationally
  always_comb begin
    done        = (state == PH_COLOR) && last_color;
    active      = (state != PH_IDLE);
    color_phase = (state == PH_COLOR);
    exact       = exact_acc;
    total       = total_acc + min_cnt;
  end

endmodule

// File: rtl/mastermind_ctrl.sv
// Game controller: slot editing, turn bookkeeping and WIN/LOSE decisions around guess_scorer.
// Define SECRET_LFSR_EN to draw the secret from an internal 16-bit LFSR instead of secret_in.
module mastermind_ctrl
  import mastermind_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int MAX_TURNS = DEF_MAX_TURNS
) (
  input  logic       clk,
  input  logic       rst_n,
  mastermind_if.slave bus
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int CODE_W = NUM_SLOTS * COLOR_W;

  game_state_t state, next_state;

  logic [COLOR_W-1:0] slots [NUM_SLOTS];
  logic [CODE_W-1:0]  guess, secret, secret_src;
  logic [SLOT_W-1:0]  cursor;
  logic [CNT_W-1:0]   exact_cnt, color_cnt, sc_exact, sc_total;
  logic [7:0]         turn_cnt;
  logic               sc_go, sc_done, sc_active, sc_color_phase;
  logic               scoring, result_valid, busy, win, lose;

`ifdef SECRET_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign secret_src = lfsr[CODE_W-1:0];
`else
  assign secret_src = bus.secret_in;
`endif

  assign scoring = (state == ST_SCORE_EXACT) || (state == ST_SCORE_COLOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // start overrides everything, including a pass already in flight
  always_comb begin
    next_state = state;
    if (bus.start) begin
      next_state = ST_ENTRY;
    end else begin
      case (state)
        ST_ENTRY:       if (bus.btn_submit) next_state = ST_SCORE_EXACT;
        ST_SCORE_EXACT: begin
          if (sc_done)             next_state = ST_REPORT;
          else if (sc_color_phase) next_state = ST_SCORE_COLOR;
        end
        ST_SCORE_COLOR: if (sc_done) next_state = ST_REPORT;
        ST_REPORT: begin
          if (exact_cnt == CNT_W'(NUM_SLOTS))    next_state = ST_WIN;
          else if (turn_cnt == 8'(MAX_TURNS))    next_state = ST_LOSE;
          else                                   next_state = ST_ENTRY;
        end
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    result_valid = 1'b0;
    busy         = 1'b0;
    win          = 1'b0;
    lose         = 1'b0;
    sc_go        = 1'b0;
    case (state)
      ST_SCORE_EXACT: begin
        busy  = 1'b1;
        sc_go = !sc_active && !bus.start;
      end
      ST_SCORE_COLOR: busy = 1'b1;
      ST_REPORT: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      ST_WIN:  win  = 1'b1;
      ST_LOSE: lose = 1'b1;
      default: ;
    endcase
  end

  // Edits only in ENTRY and only when submit is absent; colour lands on the pre-move slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      cursor    <= '0;
      secret    <= '0;
      exact_cnt <= '0;
      color_cnt <= '0;
      turn_cnt  <= '0;
    end else if (bus.start) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      cursor    <= '0;
      secret    <= secret_src;
      exact_cnt <= '0;
      color_cnt <= '0;
      turn_cnt  <= '0;
    end else if (state == ST_ENTRY && !bus.btn_submit) begin
      if (bus.btn_up && !bus.btn_down)
        slots[cursor] <= slots[cursor] + COLOR_W'(1);
      else if (bus.btn_down && !bus.btn_up)
        slots[cursor] <= slots[cursor] - COLOR_W'(1);
      if (bus.btn_right && !bus.btn_left)
        cursor <= cursor + SLOT_W'(1);
      else if (bus.btn_left && !bus.btn_right)
        cursor <= cursor - SLOT_W'(1);
    end else if (scoring && sc_done) begin
      exact_cnt <= sc_exact;
      color_cnt <= sc_total - sc_exact;
      turn_cnt  <= turn_cnt + 8'd1;
    end
  end

  always_comb begin
    guess = '0;
    for (int i = 0; i < NUM_SLOTS; i++) guess[i*COLOR_W +: COLOR_W] = slots[i];
  end

  guess_scorer #(
    .NUM_SLOTS (NUM_SLOTS),
    .COLOR_W   (COLOR_W)
  ) u_scorer (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (sc_go),
    .abort       (bus.start),
    .guess       (guess),
    .secret      (secret),
    .exact       (sc_exact),
    .total       (sc_total),
    .done        (sc_done),
    .active      (sc_active),
    .color_phase (sc_color_phase)
  );

  assign bus.guess_out    = guess;
  assign bus.cursor       = cursor;
  assign bus.exact_cnt    = exact_cnt;
  assign bus.color_cnt    = color_cnt;
  assign bus.result_valid = result_valid;
  assign bus.turn_cnt     = turn_cnt;
  assign bus.busy         = busy;
  assign bus.win          = win;
  assign bus.lose         = lose;

endmodule
